// File: rtl/dac_seq_pkg.sv
// Shared types and constants for the DAC904 waveform sequencer.
package dac_seq_pkg;

  // Sequencer states; StArm is only reachable when the trigger feature is built in.
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StArm  = 3'd1,
    StLoad = 3'd2,
    StPlay = 3'd3,
    StRamp = 3'd4
  } seq_state_e;

  // Driver control codes.
  localparam logic [7:0] CTRL_STEADY = 8'd0;
  localparam logic [7:0] CTRL_RAMP   = 8'd1;

  // Mid-scale park code for a 14-bit DAC.
  localparam logic [13:0] MID_CODE_DEFAULT = 14'h1FFF;

endpackage

// File: rtl/dac_seq_table_ram.sv
// Waveform table: simple dual-port RAM, one write port, one synchronous read-first read port.
module dac_seq_table_ram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 14
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write and read in one block; non-blocking update gives old data on a same-address collision.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dac_wave_sequencer.sv
// Sequences the DAC904 driver from a writable waveform table, or hands off to driver ramp mode.
// Optional trigger arming is built in when DAC_SEQ_TRIG_EN is defined.
module dac_wave_sequencer
  import dac_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DATA_W   = 14,
  parameter int unsigned       DWELL_W  = 16,
  parameter logic [DATA_W-1:0] MID_CODE = DATA_W'(MID_CODE_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst,
`ifdef DAC_SEQ_TRIG_EN
  input  logic               trig_in,
`endif
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [ADDR_W-1:0]  last_addr,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [7:0]         loops,
  output logic [7:0]         dac_control,
  output logic [DATA_W-1:0]  dac_data,
  output logic               busy,
  output logic               sample_strobe,
  output logic               done
);

  seq_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  last_q;
  logic [DWELL_W-1:0] dwell_q, cnt_q, cnt_d;
  logic [7:0]         loops_q, pass_q, pass_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d, next_addr, rd_port_addr;
  logic               final_q, final_d;
  logic [DATA_W-1:0]  data_q, data_d, rd_data;
  logic [7:0]         ctrl_q, ctrl_d;
  logic               strobe_d, strobe_q, done_d, done_q;
  logic               rd_en, cfg_load;

  dac_seq_table_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_table (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_port_addr),
    .rd_data (rd_data)
  );

`ifdef DAC_SEQ_TRIG_EN
  logic       mode_q;
  logic [2:0] trig_sync_q;
  logic       trig_rise;

  // Two-flop synchronizer plus one history flop for rising-edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) trig_sync_q <= '0;
    else     trig_sync_q <= {trig_sync_q[1:0], trig_in};
  end
  assign trig_rise = trig_sync_q[1] & ~trig_sync_q[2];
`endif

  // rd_addr_q is the address whose data currently sits in rd_data.
  assign next_addr = (rd_addr_q == last_q) ? '0 : rd_addr_q + ADDR_W'(1);
  assign cfg_load  = (state_q == StIdle) && start && !stop;

  // Latch the run configuration on an accepted start; ignored while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q  <= '0;
      dwell_q <= '0;
      loops_q <= '0;
`ifdef DAC_SEQ_TRIG_EN
      mode_q  <= 1'b0;
`endif
    end else if (cfg_load) begin
      last_q  <= last_addr;
      dwell_q <= dwell;
      loops_q <= loops;
`ifdef DAC_SEQ_TRIG_EN
      mode_q  <= mode;
`endif
    end
  end

  // Next-state, table read control and registered-output next values.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pass_d       = pass_q;
    rd_addr_d    = rd_addr_q;
    final_d      = final_q;
    data_d       = data_q;
    ctrl_d       = ctrl_q;
    strobe_d     = 1'b0;
    done_d       = 1'b0;
    rd_en        = 1'b0;
    rd_port_addr = next_addr;
    unique case (state_q)
      StIdle: begin
        ctrl_d = CTRL_STEADY;
        data_d = MID_CODE;
        if (start && !stop) begin
          pass_d  = '0;
          final_d = 1'b0;
`ifdef DAC_SEQ_TRIG_EN
          state_d = StArm;
`else
          state_d = mode ? StRamp : StLoad;
          ctrl_d  = mode ? CTRL_RAMP : CTRL_STEADY;
`endif
        end
      end
      StArm: begin
        ctrl_d = CTRL_STEADY;
        data_d = MID_CODE;
`ifdef DAC_SEQ_TRIG_EN
        if (trig_rise) begin
          state_d = mode_q ? StRamp : StLoad;
          ctrl_d  = mode_q ? CTRL_RAMP : CTRL_STEADY;
        end
`else
        state_d = StIdle;
`endif
      end
      StLoad: begin
        rd_en        = 1'b1;
        rd_port_addr = '0;
        rd_addr_d    = '0;
        // Pre-expire the hold so the first PLAY cycle presents table[0].
        cnt_d        = dwell_q;
        state_d      = StPlay;
      end
      StPlay: begin
        ctrl_d = CTRL_STEADY;
        if (cnt_q == dwell_q) begin
          if (final_q) begin
            state_d = StIdle;
            data_d  = MID_CODE;
            done_d  = 1'b1;
          end else begin
            // Present the prefetched sample and prefetch the following one.
            data_d    = rd_data;
            strobe_d  = 1'b1;
            cnt_d     = '0;
            rd_en     = 1'b1;
            rd_addr_d = next_addr;
            if (rd_addr_q == last_q) pass_d = pass_q + 8'd1;
            final_d = (rd_addr_q == last_q) && (loops_q != 8'd0) &&
                      ((pass_q + 8'd1) == loops_q);
          end
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      StRamp: begin
        ctrl_d = CTRL_RAMP;
        data_d = MID_CODE;
      end
      default: state_d = StIdle;
    endcase
    // Stop overrides everything outside IDLE.
    if (stop && (state_q != StIdle)) begin
      state_d  = StIdle;
      ctrl_d   = CTRL_STEADY;
      data_d   = MID_CODE;
      strobe_d = 1'b0;
      done_d   = 1'b0;
      rd_en    = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pass_q    <= '0;
      rd_addr_q <= '0;
      final_q   <= 1'b0;
      data_q    <= MID_CODE;
      ctrl_q    <= CTRL_STEADY;
      strobe_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pass_q    <= pass_d;
      rd_addr_q <= rd_addr_d;
      final_q   <= final_d;
      data_q    <= data_d;
      ctrl_q    <= ctrl_d;
      strobe_q  <= strobe_d;
      done_q    <= done_d;
    end
  end

  assign dac_control   = ctrl_q;
  assign dac_data      = data_q;
  assign busy          = (state_q != StIdle);
  assign sample_strobe = strobe_q;
  assign done          = done_q;

endmodule

// File: tb/tb_dac_wave_sequencer.sv
// Scoreboard bench for dac_wave_sequencer: stimulus pushes expected events, a monitor pops them.
module tb_dac_wave_sequencer;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 14;
  localparam int unsigned DWELL_W = 16;
  localparam logic [DATA_W-1:0] MID = 14'h1FFF;

  logic               clk = 1'b0;
  logic               rst;
`ifdef DAC_SEQ_TRIG_EN
  logic               trig_in;
`endif
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic               start, stop, mode;
  logic [ADDR_W-1:0]  last_addr;
  logic [DWELL_W-1:0] dwell;
  logic [7:0]         loops;
  logic [7:0]         dac_control;
  logic [DATA_W-1:0]  dac_data;
  logic               busy, sample_strobe, done;

  always #5 clk = ~clk;

  dac_wave_sequencer dut (
    .clk           (clk),
    .rst           (rst),
`ifdef DAC_SEQ_TRIG_EN
    .trig_in       (trig_in),
`endif
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .start         (start),
    .stop          (stop),
    .mode          (mode),
    .last_addr     (last_addr),
    .dwell         (dwell),
    .loops         (loops),
    .dac_control   (dac_control),
    .dac_data      (dac_data),
    .busy          (busy),
    .sample_strobe (sample_strobe),
    .done          (done)
  );

  typedef struct {
    bit                is_done;
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  exp_t              sb[$];
  exp_t              mon_e;
  int                cyc = 0;
  int                n_pass = 0;
  int                n_total = 0;
  logic [DATA_W-1:0] tbl_model [2**ADDR_W];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every strobe or done must match the head of the scoreboard, including its cycle.
  always @(posedge clk) begin
    #1;
    if (!rst && (sample_strobe || done)) begin
      check("event_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("evt_done", 32'(done), 32'(mon_e.is_done));
        check("evt_strobe", 32'(sample_strobe), 32'(!mon_e.is_done));
        check("evt_data", 32'(dac_data), 32'(mon_e.data));
        check("evt_cycle", cyc, mon_e.cyc);
        check("evt_ctrl", 32'(dac_control), 32'd0);
      end
    end
  end

  task automatic write_tbl(input int a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = ADDR_W'(a);
    wr_data = d;
    tbl_model[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic check_parked(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ctrl"}, 32'(dac_control), 32'd0);
    check({tag, "_data"}, 32'(dac_data), 32'(MID));
  endtask

  // Issue start; returns the edge count equivalent to the start edge (trigger edge when armed).
  task automatic do_start(input bit m, input int last, input int dw, input int lp, output int n);
    @(negedge clk);
    mode = m;
    last_addr = ADDR_W'(last);
    dwell = DWELL_W'(dw);
    loops = 8'(lp);
    start = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    start = 1'b0;
    // Config is latched; new values must be ignored while busy.
    last_addr = ADDR_W'($urandom);
    dwell = DWELL_W'($urandom);
    loops = 8'($urandom);
    mode = 1'($urandom);
    check("start_busy", 32'(busy), 32'd1);
`ifdef DAC_SEQ_TRIG_EN
    repeat (3) @(negedge clk);
    check("armed_busy", 32'(busy), 32'd1);
    check("armed_data", 32'(dac_data), 32'(MID));
    trig_in = 1'b1;
    n = cyc + 3;  // two synchronizer edges plus the detect edge
    @(negedge clk);
    trig_in = 1'b0;
`endif
  endtask

  // Table playback run; lp=0 plays k_inf samples then stops just before the next one.
  task automatic play(input int last, input int dw, input int lp, input int k_inf, input bit restart);
    int n, total, tk;
    do_start(1'b0, last, dw, lp, n);
    total = (lp != 0) ? lp * (last + 1) : k_inf;
    for (int k = 0; k < total; k++)
      sb.push_back(exp_t'{1'b0, tbl_model[k % (last + 1)], n + 2 + k * (dw + 1)});
    if (lp != 0) sb.push_back(exp_t'{1'b1, MID, n + 2 + total * (dw + 1)});
    if (restart) begin
      repeat (3) @(negedge clk);
      last_addr = ADDR_W'(last + 5);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    if (lp != 0) begin
      for (int i = 0; i < 5000 && sb.size() != 0; i++) @(negedge clk);
      check("drain", sb.size(), 0);
      check_parked("after_done");
    end else begin
      tk = n + 2 + k_inf * (dw + 1);
      for (int i = 0; i < 5000 && cyc < tk - 1; i++) @(negedge clk);
      stop = 1'b1;
      @(posedge clk);
      #1;
      stop = 1'b0;
      check_parked("after_stop");
      @(negedge clk);
      check("drain_inf", sb.size(), 0);
    end
  endtask

  initial begin
    int n;
    int t3;
    rst = 1'b1;
`ifdef DAC_SEQ_TRIG_EN
    trig_in = 1'b0;
`endif
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; mode = 1'b0;
    last_addr = '0; dwell = '0; loops = '0;
    repeat (2) @(negedge clk);
    check_parked("reset");
    check("reset_strobe", 32'(sample_strobe), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst = 1'b0;

    // Directed four-sample table, two passes, dwell 1.
    write_tbl(0, 14'h0000);
    write_tbl(1, 14'h1000);
    write_tbl(2, 14'h2000);
    write_tbl(3, 14'h3FFF);
    play(3, 1, 2, 0, 1'b0);

    // Randomized finite and infinite runs.
    for (int a = 0; a < 16; a++) write_tbl(a, DATA_W'($urandom));
    repeat (4) play($urandom_range(7, 0), $urandom_range(3, 0), $urandom_range(3, 1), 0, 1'b0);
    play($urandom_range(7, 0), $urandom_range(3, 0), 0, $urandom_range(12, 4), 1'b0);

    // A second start while playing must not disturb the running sequence.
    play(3, 2, 2, 0, 1'b1);

    // start and stop together in IDLE.
    @(negedge clk);
    start = 1'b1;
    stop = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop = 1'b0;
    check("start_stop_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("start_stop_busy_later", 32'(busy), 32'd0);

    // Ramp hand-off, with table writes accepted meanwhile; no done may appear.
    do_start(1'b1, 0, 0, 1, n);
    for (int i = 0; i < 500 && cyc < n; i++) @(negedge clk);
    check("ramp_ctrl", 32'(dac_control), 32'd1);
    check("ramp_busy", 32'(busy), 32'd1);
    check("ramp_data", 32'(dac_data), 32'(MID));
    write_tbl(0, 14'h0ABC);
    for (int i = 0; i < 500 && cyc < n + 100; i++) @(negedge clk);
    check("ramp_ctrl_held", 32'(dac_control), 32'd1);
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    check_parked("ramp_stop");

    // Single-sample table with zero dwell: strobe every cycle until stop.
    play(0, 0, 0, 20, 1'b0);

    // Asynchronous reset in the middle of playback.
    do_start(1'b0, 3, 2, 0, n);
    for (int k = 0; k < 3; k++) sb.push_back(exp_t'{1'b0, tbl_model[k], n + 2 + k * 3});
    t3 = n + 2 + 3 * 3;
    for (int i = 0; i < 500 && cyc < t3 - 1; i++) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_parked("async_reset");
    check("async_reset_strobe", 32'(sample_strobe), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_parked("post_reset");
    check("reset_drain", sb.size(), 0);

`ifdef DAC_SEQ_TRIG_EN
    // stop while armed returns to IDLE; a later trigger must not start anything.
    @(negedge clk);
    mode = 1'b0;
    last_addr = '0;
    loops = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("arm_busy", 32'(busy), 32'd1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_parked("arm_stop");
    trig_in = 1'b1;
    repeat (6) @(negedge clk);
    trig_in = 1'b0;
    check_parked("arm_stop_trig");
`endif

    repeat (3) @(negedge clk);
    check("final_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
